// File: rtl/down_counter_timer_pkg.sv
// -----------------------------------------------------------------------------
// down_counter_timer_pkg
// Shared definitions for the counter family: the control state encoding
// and its width. The up counters import the same package.
// -----------------------------------------------------------------------------
package down_counter_timer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/down_counter_timer_if.sv
// -----------------------------------------------------------------------------
// down_counter_timer_if
// Control/status bundle of the down-counting timer.
//   master : drives load/load_value/start/stop/auto_reload, observes status
//   slave  : the timer itself; observes controls, drives count/busy/done/tc_pulse
// -----------------------------------------------------------------------------
interface down_counter_timer_if #(
  parameter int WIDTH = 8
);

  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc_pulse;

  modport master (
    output load, load_value, start, stop, auto_reload,
    input  count, busy, done, tc_pulse
  );

  modport slave (
    input  load, load_value, start, stop, auto_reload,
    output count, busy, done, tc_pulse
  );

endinterface

// File: rtl/down_counter_timer.sv
// -----------------------------------------------------------------------------
// down_counter_timer
// Programmable down-counting timer. A loaded value is counted down to zero;
// at terminal count a one-cycle tc_pulse is issued and the timer either
// stops (one-shot, sticky done) or reloads and keeps running.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : control/status bundle (slave side)
// Per-cycle priority: load > stop > start > counting. All outputs registered.
// -----------------------------------------------------------------------------
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  down_counter_timer_if.slave   bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] start_val_s;

  // Value a start would begin counting from: DONE restarts from the reload value.
  always_comb begin
    start_val_s = count_q;
    if (state_q == ST_DONE) begin
      start_val_s = reload_q;
    end else begin
      start_val_s = count_q;
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = done_q;
    tc_d     = 1'b0;

    if (bus.load) begin
      // Load overrides everything, including a decrement due this cycle.
      count_d  = bus.load_value;
      reload_d = bus.load_value;
      state_d  = ST_IDLE;
      done_d   = 1'b0;
    end else if (bus.stop) begin
      // Stop only acts in RUN, but it always masks a simultaneous start.
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSED;
      end else begin
        state_d = state_q;
      end
    end else if (bus.start && (state_q != ST_RUN)) begin
      count_d = start_val_s;
      if (start_val_s == '0) begin
        // Nothing to count: terminal count immediately.
        state_d = ST_DONE;
        tc_d    = 1'b1;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
        done_d  = 1'b0;
      end
    end else if (state_q == ST_RUN) begin
      case (count_q)
        WIDTH'(0): begin
          // Only reachable on the auto-reload path.
          count_d = reload_q;
          tc_d    = (reload_q == '0);
        end
        WIDTH'(1): begin
          count_d = '0;
          tc_d    = 1'b1;
          if (!bus.auto_reload) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          count_d = count_q - WIDTH'(1);
        end
      endcase
    end else begin
      state_d = state_q;
    end

    busy_d = (state_d == ST_RUN);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tc_pulse = tc_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// -----------------------------------------------------------------------------
// tb_down_counter_timer
// Directed bench for down_counter_timer. Inputs change 1 time unit after the
// rising edge; outputs are checked at that same point, so each check reflects
// the edge just taken.
// -----------------------------------------------------------------------------
module tb_down_counter_timer;

  localparam int WIDTH = 8;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  down_counter_timer_if #(.WIDTH(WIDTH)) dif ();

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int cnt, input bit busy,
                           input bit done, input bit tc);
    check({tag, ".count"}, 32'(dif.count), 32'(cnt));
    check({tag, ".busy"},  32'(dif.busy),  32'(busy));
    check({tag, ".done"},  32'(dif.done),  32'(done));
    check({tag, ".tc"},    32'(dif.tc_pulse), 32'(tc));
  endtask

  int exp_auto_cnt [6] = '{1, 0, 2, 1, 0, 2};
  bit exp_auto_tc  [6] = '{0, 1, 0, 0, 1, 0};

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    dif.load = 1'b0;
    dif.load_value = '0;
    dif.start = 1'b0;
    dif.stop = 1'b0;
    dif.auto_reload = 1'b0;

    tick();
    tick();
    check_all("reset", 0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick();
    check_all("idle_after_reset", 0, 1'b0, 1'b0, 1'b0);

    // One-shot of 3.
    dif.load = 1'b1; dif.load_value = 8'd3;
    tick();
    check_all("os_load", 3, 1'b0, 1'b0, 1'b0);
    dif.load = 1'b0; dif.start = 1'b1;
    tick();
    check_all("os_start", 3, 1'b1, 1'b0, 1'b0);
    dif.start = 1'b0;
    tick(); check_all("os_e2", 2, 1'b1, 1'b0, 1'b0);
    tick(); check_all("os_e3", 1, 1'b1, 1'b0, 1'b0);
    tick(); check_all("os_e4", 0, 1'b0, 1'b1, 1'b1);
    tick(); check_all("os_hold", 0, 1'b0, 1'b1, 1'b0);
    // Stop outside RUN does nothing.
    dif.stop = 1'b1;
    tick(); check_all("os_stop_done", 0, 1'b0, 1'b1, 1'b0);
    dif.stop = 1'b0;

    // Auto-reload of 2: 1,0,2,1,0,2 with tc every third cycle.
    dif.auto_reload = 1'b1;
    dif.load = 1'b1; dif.load_value = 8'd2;
    tick(); check_all("ar_load", 2, 1'b0, 1'b0, 1'b0);
    dif.load = 1'b0; dif.start = 1'b1;
    tick(); check_all("ar_start", 2, 1'b1, 1'b0, 1'b0);
    dif.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_all($sformatf("ar_step%0d", i), exp_auto_cnt[i], 1'b1, 1'b0, exp_auto_tc[i]);
    end

    // Pause/resume from 10.
    dif.auto_reload = 1'b0;
    dif.load = 1'b1; dif.load_value = 8'd10;
    tick(); check_all("pr_load", 10, 1'b0, 1'b0, 1'b0);
    dif.load = 1'b0; dif.start = 1'b1;
    tick(); check_all("pr_start", 10, 1'b1, 1'b0, 1'b0);
    dif.start = 1'b0;
    for (int i = 9; i >= 6; i--) begin
      tick();
      check_all($sformatf("pr_cnt%0d", i), i, 1'b1, 1'b0, 1'b0);
    end
    dif.stop = 1'b1;
    tick(); check_all("pr_stop", 6, 1'b0, 1'b0, 1'b0);
    dif.stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all($sformatf("pr_hold%0d", i), 6, 1'b0, 1'b0, 1'b0);
    end
    dif.start = 1'b1; dif.stop = 1'b1;
    tick(); check_all("pr_start_stop", 6, 1'b0, 1'b0, 1'b0);
    dif.stop = 1'b0;
    tick(); check_all("pr_resume", 6, 1'b1, 1'b0, 1'b0);
    dif.start = 1'b0;
    tick(); check_all("pr_dec", 5, 1'b1, 1'b0, 1'b0);

    // Load beats start while running.
    dif.load = 1'b1; dif.load_value = 8'd7; dif.start = 1'b1;
    tick(); check_all("lp_load", 7, 1'b0, 1'b0, 1'b0);
    dif.load = 1'b0; dif.start = 1'b0;
    tick(); check_all("lp_idle", 7, 1'b0, 1'b0, 1'b0);

    // Zero value: immediate terminal count.
    dif.load = 1'b1; dif.load_value = 8'd0;
    tick(); check_all("z_load", 0, 1'b0, 1'b0, 1'b0);
    dif.load = 1'b0; dif.start = 1'b1;
    tick(); check_all("z_start", 0, 1'b0, 1'b1, 1'b1);
    dif.start = 1'b0;
    tick(); check_all("z_after", 0, 1'b0, 1'b1, 1'b0);

    // Reach DONE with reload 4, then restart from DONE.
    dif.load = 1'b1; dif.load_value = 8'd4;
    tick(); check_all("r4_load", 4, 1'b0, 1'b0, 1'b0);
    dif.load = 1'b0; dif.start = 1'b1;
    tick(); check_all("r4_start", 4, 1'b1, 1'b0, 1'b0);
    dif.start = 1'b0;
    for (int i = 3; i >= 1; i--) begin
      tick(); check_all($sformatf("r4_a%0d", i), i, 1'b1, 1'b0, 1'b0);
    end
    tick(); check_all("r4_a0", 0, 1'b0, 1'b1, 1'b1);
    dif.start = 1'b1;
    tick(); check_all("r4_restart", 4, 1'b1, 1'b0, 1'b0);
    dif.start = 1'b0;
    for (int i = 3; i >= 1; i--) begin
      tick(); check_all($sformatf("r4_b%0d", i), i, 1'b1, 1'b0, 1'b0);
    end
    tick(); check_all("r4_b0", 0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset at count 5.
    dif.load = 1'b1; dif.load_value = 8'd8;
    tick();
    dif.load = 1'b0; dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    tick(); tick(); tick();
    check_all("rst_pre", 5, 1'b1, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("rst_async", 0, 1'b0, 1'b0, 1'b0);
    tick(); check_all("rst_held", 0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick(); check_all("rst_release", 0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
